// File: rtl/mont_pkg.sv
// Purpose: shared constants and FSM state codes for the Montgomery multiply sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mont_pkg;

    // Default operand/modulus width and the derived adder and bit-counter widths.
    localparam int MONT_WIDTH = 1024;
    localparam int MONT_ADD_W = MONT_WIDTH + 4;
    localparam int MONT_CNT_W = $clog2(MONT_WIDTH) + 1;

    // Sequencer states.
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_CHK_A    = 4'd1;
    localparam logic [3:0] ST_ADD_B    = 4'd2;
    localparam logic [3:0] ST_WAIT_B   = 4'd3;
    localparam logic [3:0] ST_CHK_ODD  = 4'd4;
    localparam logic [3:0] ST_ADD_M    = 4'd5;
    localparam logic [3:0] ST_WAIT_M   = 4'd6;
    localparam logic [3:0] ST_SHIFT    = 4'd7;
    localparam logic [3:0] ST_SUB      = 4'd8;
    localparam logic [3:0] ST_WAIT_SUB = 4'd9;
    localparam logic [3:0] ST_DONE     = 4'd10;

endpackage

// File: rtl/mont_ctrl.sv
// Purpose: sequences an external multi-cycle adder to compute C = A*B*2^-WIDTH mod M.
// Latency: per bit 3 cycles + (1+L) per adder op, then 2+L for the final subtract, then done.
// Backpressure: none; start is ignored while busy, the adder is awaited without timeout.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   start, in_a/b/m       one-cycle request, operands sampled with it
//   result, done, busy    product (held), one-cycle completion pulse, job in flight
//   add_*                 handshake and operands for the shared adder instance
module mont_ctrl
    import mont_pkg::*;
#(
    parameter int WIDTH = MONT_WIDTH,
    parameter int ADD_W = WIDTH + 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             add_start,
    output logic             add_subtract,
    output logic             add_shift,
    output logic [ADD_W-1:0] add_in_a,
    output logic [ADD_W-1:0] add_in_b,
    input  logic [ADD_W:0]   add_result,
    input  logic             add_done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH);

    logic [3:0]       state;
    logic [WIDTH-1:0] a_sh;     // A shifted right once per bit, so a_sh[0] is A[i]
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] m_q;
    logic [ADD_W-1:0] c_q;      // running partial product, always < 2M
    logic [CNT_W-1:0] bit_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            a_sh    <= '0;
            b_q     <= '0;
            m_q     <= '0;
            c_q     <= '0;
            bit_cnt <= '0;
            result  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh    <= in_a;
                        b_q     <= in_b;
                        m_q     <= in_m;
                        c_q     <= '0;
                        bit_cnt <= '0;
                        state   <= ST_CHK_A;
                    end
                end
                ST_CHK_A: begin
                    if (bit_cnt == BIT_LAST) begin
                        state <= ST_SUB;
                    end else if (a_sh[0]) begin
                        state <= ST_ADD_B;
                    end else begin
                        state <= ST_CHK_ODD;
                    end
                end
                ST_ADD_B: state <= ST_WAIT_B;
                ST_WAIT_B: begin
                    if (add_done) begin
                        c_q   <= add_result[ADD_W-1:0];
                        state <= ST_CHK_ODD;
                    end
                end
                ST_CHK_ODD: state <= c_q[0] ? ST_ADD_M : ST_SHIFT;
                ST_ADD_M: state <= ST_WAIT_M;
                ST_WAIT_M: begin
                    if (add_done) begin
                        c_q   <= add_result[ADD_W-1:0];
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    c_q     <= c_q >> 1;
                    a_sh    <= a_sh >> 1;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    state   <= ST_CHK_A;
                end
                ST_SUB: state <= ST_WAIT_SUB;
                ST_WAIT_SUB: begin
                    if (add_done) begin
                        // Top bit of the difference is the borrow: C < M keeps C.
                        result <= add_result[ADD_W] ? c_q[WIDTH-1:0]
                                                    : add_result[WIDTH-1:0];
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decode the state register directly; the launch states
    // last exactly one cycle, so add_start is a single-cycle pulse.
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);
    assign add_start    = (state == ST_ADD_B) || (state == ST_ADD_M) || (state == ST_SUB);
    assign add_subtract = (state == ST_SUB) || (state == ST_WAIT_SUB);
    assign add_shift    = 1'b0;
    assign add_in_a     = c_q;
    assign add_in_b     = ((state == ST_ADD_B) || (state == ST_WAIT_B))
                          ? {{(ADD_W-WIDTH){1'b0}}, b_q}
                          : {{(ADD_W-WIDTH){1'b0}}, m_q};

endmodule
